// File: rtl/ocd_pkg.sv
// Shared encodings for the OCD memory access sequencer: FSM states and
// bit positions inside the AC/D scan chain words.
package ocd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_REQ    = 2'd2,
        ST_RDWAIT = 2'd3
    } ocd_state_t;

    localparam int AC_W      = 19;
    localparam int D_W       = 9;

    // chain_ac_o fields
    localparam int ADDR_MSB  = 15;
    localparam int WR_BIT    = 16;
    localparam int SPACE_BIT = 17;
    localparam int AINC_BIT  = 18;

    // chain_ac_i status fields
    localparam int BUSY_BIT  = 18;
    localparam int ERR_BIT   = 17;
    localparam int OVR_BIT   = 16;

    // chain_d_i status field
    localparam int RDV_BIT   = 8;

endpackage

// File: rtl/ocd_toggle_sync.sv
// Carries a one-tck update pulse into the clk domain as a one-clk event:
// tck toggle flop, 2-FF synchroniser, then an edge-detect stage.
module ocd_toggle_sync (
    input  logic tck,
    input  logic clk,
    input  logic trst_n,
    input  logic pulse_tck,
    output logic event_clk
);

    logic       tog_tck;
    logic [2:0] sync_q;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tog_tck <= 1'b0;
        end else if (pulse_tck) begin
            tog_tck <= ~tog_tck;
        end
    end

    // sync_q[2] is the edge-detect reference; event is registered so it
    // appears on the 3rd clk edge after the toggle flips.
    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            sync_q    <= 3'b000;
            event_clk <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], tog_tck};
            event_clk <= sync_q[1] ^ sync_q[2];
        end
    end

endmodule

// File: rtl/ocd_mem_ctrl.sv
// Debugger memory access sequencer: decodes scan-chain commands and runs single
// read/write cycles on the core memory port.
//
//   state  | meaning
//   IDLE   | no access pending; waiting for an AC command
//   ARMED  | write command latched; waiting for D update with the data
//   REQ    | mem_req asserted until mem_gnt or timeout
//   RDWAIT | read granted; waiting for mem_rvalid or timeout
module ocd_mem_ctrl
    import ocd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int ADDR_W      = 16
) (
    input  logic              tck,
    input  logic              clk,
    input  logic              trst_n,
    input  logic [AC_W-1:0]   chain_ac_o,
    input  logic [D_W-1:0]    chain_d_o,
    input  logic              chain_ac_ud,
    input  logic              chain_d_ud,
    output logic [AC_W-1:0]   chain_ac_i,
    output logic [D_W-1:0]    chain_d_i,
    input  logic              dbg_halted,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_space,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid
);

    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYC - 1);

    ocd_state_t        state, state_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic              wr_q, wr_nx;
    logic              space_q, space_nx;
    logic              ainc_q, ainc_nx;
    logic              err_q, err_nx;
    logic              ovr_q, ovr_nx;
    logic              rdv_q, rdv_nx;
    logic              rd_done_q, rd_done_nx;
    logic [7:0]        rdata_q, rdata_nx;
    logic [7:0]        wdata_q, wdata_nx;
    logic [15:0]       tmo_q, tmo_nx;
    logic              ev_ac, ev_d;
    logic              busy;
    logic              unused_d;

    assign unused_d = chain_d_o[8];

    ocd_toggle_sync u_sync_ac (
        .tck       (tck),
        .clk       (clk),
        .trst_n    (trst_n),
        .pulse_tck (chain_ac_ud),
        .event_clk (ev_ac)
    );

    ocd_toggle_sync u_sync_d (
        .tck       (tck),
        .clk       (clk),
        .trst_n    (trst_n),
        .pulse_tck (chain_d_ud),
        .event_clk (ev_d)
    );

    assign busy = (state == ST_REQ) || (state == ST_RDWAIT);

    always_comb begin
        state_nx   = state;
        addr_nx    = addr_q;
        wr_nx      = wr_q;
        space_nx   = space_q;
        ainc_nx    = ainc_q;
        err_nx     = err_q;
        ovr_nx     = ovr_q;
        rdv_nx     = rdv_q;
        rd_done_nx = rd_done_q;
        rdata_nx   = rdata_q;
        wdata_nx   = wdata_q;
        tmo_nx     = TMO_LOAD;
        case (state)
            ST_IDLE, ST_ARMED: begin
                if (ev_ac) begin
                    // ev_d arriving with ev_ac loses and is reported as overrun
                    addr_nx    = chain_ac_o[ADDR_W-1:0];
                    wr_nx      = chain_ac_o[WR_BIT];
                    space_nx   = chain_ac_o[SPACE_BIT];
                    ainc_nx    = chain_ac_o[AINC_BIT];
                    err_nx     = 1'b0;
                    ovr_nx     = ev_d;
                    rd_done_nx = 1'b0;
                    if (!dbg_halted) begin
                        err_nx   = 1'b1;
                        state_nx = ST_IDLE;
                    end else if (chain_ac_o[WR_BIT]) begin
                        state_nx = ST_ARMED;
                    end else begin
                        rdv_nx   = 1'b0;
                        state_nx = ST_REQ;
                    end
                end else if (state == ST_ARMED && !dbg_halted) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (ev_d) begin
                    if (state == ST_ARMED) begin
                        wdata_nx = chain_d_o[7:0];
                        state_nx = ST_REQ;
                    end else if (rd_done_q && ainc_q) begin
                        if (!dbg_halted) begin
                            err_nx     = 1'b1;
                            rd_done_nx = 1'b0;
                        end else begin
                            rdv_nx   = 1'b0;
                            state_nx = ST_REQ;
                        end
                    end
                end
            end
            ST_REQ: begin
                if (ev_ac || ev_d) ovr_nx = 1'b1;
                if (mem_gnt) begin
                    if (wr_q) begin
                        if (ainc_q) addr_nx = addr_q + ADDR_W'(1);
                        state_nx = ST_ARMED;
                    end else begin
                        state_nx = ST_RDWAIT;
                    end
                end else if (tmo_q == 16'd0) begin
                    err_nx     = 1'b1;
                    rd_done_nx = 1'b0;
                    state_nx   = ST_IDLE;
                end else begin
                    tmo_nx = tmo_q - 16'd1;
                end
            end
            ST_RDWAIT: begin
                if (ev_ac || ev_d) ovr_nx = 1'b1;
                if (mem_rvalid) begin
                    rdata_nx   = mem_rdata;
                    rdv_nx     = 1'b1;
                    rd_done_nx = 1'b1;
                    if (ainc_q) addr_nx = addr_q + ADDR_W'(1);
                    state_nx   = ST_IDLE;
                end else if (tmo_q == 16'd0) begin
                    err_nx     = 1'b1;
                    rd_done_nx = 1'b0;
                    state_nx   = ST_IDLE;
                end else begin
                    tmo_nx = tmo_q - 16'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            space_q   <= 1'b0;
            ainc_q    <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            rdv_q     <= 1'b0;
            rd_done_q <= 1'b0;
            rdata_q   <= 8'h00;
            wdata_q   <= 8'h00;
            tmo_q     <= TMO_LOAD;
        end else begin
            state     <= state_nx;
            addr_q    <= addr_nx;
            wr_q      <= wr_nx;
            space_q   <= space_nx;
            ainc_q    <= ainc_nx;
            err_q     <= err_nx;
            ovr_q     <= ovr_nx;
            rdv_q     <= rdv_nx;
            rd_done_q <= rd_done_nx;
            rdata_q   <= rdata_nx;
            wdata_q   <= wdata_nx;
            tmo_q     <= tmo_nx;
        end
    end

    assign mem_req   = (state == ST_REQ);
    assign mem_we    = mem_req & wr_q;
    assign mem_space = space_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        chain_ac_i              = '0;
        chain_ac_i[BUSY_BIT]    = busy;
        chain_ac_i[ERR_BIT]     = err_q;
        chain_ac_i[OVR_BIT]     = ovr_q;
        chain_ac_i[ADDR_MSB:0]  = 16'(addr_q);
        chain_d_i               = {rdv_q, rdata_q};
    end

endmodule
